// File: rtl/datapath_pkg.sv
// Shared definitions for the multicycle datapath: opcodes, FSM states, flag bits, IR fields.
package datapath_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_LD   = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01010;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_JZ   = 5'b01101;
  localparam logic [4:0] OP_JC   = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // ALU sub-opcodes carried in ir[13:11] of the 00ooo group
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_MOV = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int ALU_HI = 13;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 3;
  localparam int RB_HI  = 2;
  localparam int RB_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic is_alu(input logic [4:0] op);
    return op[4:3] == 2'b00;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations, flags {V,N,C,Z}; C is carry (ADD), borrow (SUB) or shifted-out bit.
module alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags
);

  logic [DATA_W:0] wide;
  logic            carry;
  logic            ovf;

  always_comb begin
    wide  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    y     = '0;
    case (op)
      ALU_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      ALU_SHR: begin
        y     = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      default: y = a;
    endcase
    flags = '0;
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_N] = y[DATA_W-1];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/dp_ctrl_fsm.sv
// Fetch/decode/execute/memory control FSM; emits per-state strobes and exposes its state.
// Branch control (flags in, pc_load out) exists only with DATAPATH_MC_BRANCH_EN.
module dp_ctrl_fsm
  import datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dmem_ack,
  input  logic [4:0] dec_op,
  input  logic [4:0] exec_op,
  output state_t     state,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       flags_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       cap_en
`ifdef DATAPATH_MC_BRANCH_EN
  ,
  input  logic [3:0] flags,
  output logic       pc_load
`endif
);

  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    flags_we   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    cap_en     = 1'b0;
`ifdef DATAPATH_MC_BRANCH_EN
    pc_load    = 1'b0;
`endif
    case (state)
      S_FETCH: if (run) state_next = S_DECODE;
      S_DECODE: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        if (dec_op == OP_LD || dec_op == OP_ST) state_next = S_MEM;
        else if (dec_op == OP_HALT)             state_next = S_HALT;
        else                                    state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH;
        if (is_alu(exec_op)) begin
          reg_we   = 1'b1;
          flags_we = 1'b1;
        end else if (exec_op == OP_LDI) begin
          reg_we = 1'b1;
        end
`ifdef DATAPATH_MC_BRANCH_EN
        case (exec_op)
          OP_JMP:  pc_load = 1'b1;
          OP_JZ:   pc_load = flags[FLAG_Z];
          OP_JC:   pc_load = flags[FLAG_C];
          default: pc_load = 1'b0;
        endcase
`endif
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (exec_op == OP_ST);
        if (dmem_ack) begin
          if (exec_op == OP_ST) begin
            state_next = S_FETCH;
          end else begin
            cap_en     = 1'b1;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/memory_bank.sv
// Code store: 16-bit words, synchronous write and one-cycle synchronous read.
module memory_bank #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/register_bank.sv
// Eight-entry register file, two combinational read ports, one synchronous write port.
module register_bank #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra];
  assign rd_b = regs[rb];

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath top: PC, IR, flags, load capture, code store, register file and ALU.
// Conditional/unconditional branches are built only with DATAPATH_MC_BRANCH_EN defined.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CODE_ADDR_W = 9,
  parameter int DATA_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   code_w_en,
  input  logic [CODE_ADDR_W-1:0] code_addr_in,
  input  logic [15:0]            code_in,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic [DATA_W-1:0]      dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   halted,
  output logic [CODE_ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0]      debug
);

  state_t                 state;
  logic                   ir_load, pc_inc, reg_we, wb_sel, flags_we, mem_req, mem_we, cap_en;
  logic [CODE_ADDR_W-1:0] pc, code_addr;
  logic [15:0]            ir, code_out;
  logic [3:0]             flags, alu_flags;
  logic [DATA_W-1:0]      cap, rd_a, rd_b, alu_y, wd, debug_q;
  logic                   code_wr;

  // Writes are only accepted while stopped; otherwise the store always reads at PC
  assign code_wr   = code_w_en && !run;
  assign code_addr = code_wr ? code_addr_in : pc;

  memory_bank #(.ADDR_W(CODE_ADDR_W)) u_code (
    .clk(clk), .we(code_wr), .addr(code_addr), .wdata(code_in), .rdata(code_out)
  );

`ifdef DATAPATH_MC_BRANCH_EN
  logic pc_load;
`endif

  dp_ctrl_fsm u_ctrl (
    .clk(clk), .rst(rst), .run(run), .dmem_ack(dmem_ack),
    .dec_op(code_out[OP_HI:OP_LO]), .exec_op(ir[OP_HI:OP_LO]),
    .state(state), .ir_load(ir_load), .pc_inc(pc_inc), .reg_we(reg_we),
    .wb_sel(wb_sel), .flags_we(flags_we), .mem_req(mem_req), .mem_we(mem_we),
    .cap_en(cap_en)
`ifdef DATAPATH_MC_BRANCH_EN
    , .flags(flags), .pc_load(pc_load)
`endif
  );

  register_bank #(.DATA_W(DATA_W)) u_regs (
    .clk(clk), .rst(rst), .we(reg_we), .wa(ir[RD_HI:RD_LO]),
    .ra(ir[RA_HI:RA_LO]), .rb(ir[RB_HI:RB_LO]), .wd(wd), .rd_a(rd_a), .rd_b(rd_b)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .a(rd_a), .b(rd_b), .op(ir[ALU_HI:OP_LO]), .y(alu_y), .flags(alu_flags)
  );

  always_comb begin
    wd = DATA_W'(ir[IMM_HI:IMM_LO]);
    if (wb_sel)                        wd = cap;
    else if (is_alu(ir[OP_HI:OP_LO]))  wd = alu_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      flags   <= '0;
      cap     <= '0;
      debug_q <= '0;
    end else begin
`ifdef DATAPATH_MC_BRANCH_EN
      if (pc_load)     pc <= ir[CODE_ADDR_W-1:0];
      else if (pc_inc) pc <= pc + 1'b1;
`else
      if (pc_inc) pc <= pc + 1'b1;
`endif
      if (ir_load)  ir      <= code_out;
      if (flags_we) flags   <= alu_flags;
      if (cap_en)   cap     <= dmem_rdata;
      if (reg_we)   debug_q <= wd;
    end
  end

`ifndef DATAPATH_MC_BRANCH_EN
  // Flags are architectural state even when nothing branches on them
  logic unused_flags;
  assign unused_flags = ^flags;
`endif

  // Bus fields are forced to zero outside MEM so idle/reset values are clean
  assign dmem_req   = mem_req;
  assign dmem_we    = mem_we;
  assign dmem_addr  = mem_req ? DATA_ADDR_W'(ir[IMM_HI:IMM_LO]) : '0;
  assign dmem_wdata = mem_we ? rd_a : '0;
  assign halted     = (state == S_HALT);
  assign pc_out     = pc;
  assign debug      = debug_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Self-checking bench for datapath_mc: directed ALU/branch tables plus memory, wrap, run and reset sequences.
module tb_datapath_mc;

  logic       clk, rst, run, code_w_en, dmem_ack;
  logic [8:0] code_addr_in;
  logic [15:0] code_in;
  logic       dmem_req, dmem_we, halted;
  logic [9:0] dmem_addr;
  logic [7:0] dmem_wdata, dmem_rdata, debug;
  logic [8:0] pc_out;

  int tests = 0;
  int fails = 0;

  datapath_mc dut (
    .clk(clk), .rst(rst), .run(run), .code_w_en(code_w_en), .code_addr_in(code_addr_in),
    .code_in(code_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halted(halted), .pc_out(pc_out), .debug(debug)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; dmem_ack = 1'b0; code_w_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [8:0] a, input logic [15:0] d);
    code_w_en = 1'b1; code_addr_in = a; code_in = d;
    tick();
    code_w_en = 1'b0;
  endtask

  task automatic run_to_halt(output int cycles);
    run = 1'b1;
    cycles = 0;
    while (!halted && cycles < 3000) begin
      tick();
      cycles++;
    end
    run = 1'b0;
  endtask

  // Waits for req, checks bus stability each MEM cycle, then acks after 'delay' cycles
  task automatic mem_service(input string name, input int delay, input logic exp_we,
                             input logic [9:0] exp_addr, input logic [7:0] exp_wdata,
                             input logic [7:0] rdata, output int wait_cycles);
    int req_cyc;
    wait_cycles = 0;
    while (!dmem_req && wait_cycles < 50) begin
      tick();
      wait_cycles++;
    end
    check({name, "_req_seen"}, dmem_req, 1);
    req_cyc = 0;
    for (int i = 0; i <= delay; i++) begin
      check({name, "_addr"}, dmem_addr, exp_addr);
      check({name, "_we"}, dmem_we, exp_we);
      if (exp_we) check({name, "_wdata"}, dmem_wdata, exp_wdata);
      if (dmem_req) req_cyc++;
      if (i < delay) tick();
    end
    dmem_rdata = rdata;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check({name, "_req_cycles"}, req_cyc, delay + 1);
    check({name, "_req_low_after_ack"}, dmem_req, 0);
    check({name, "_addr_idle"}, dmem_addr, 0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_y;
    string      name;
  } alu_vec_t;

  typedef struct {
    logic [15:0] prog [5];
    int          cycles;
    logic [8:0]  exp_pc;
    string       name;
  } br_vec_t;

  alu_vec_t alu_vecs [10];
  br_vec_t  br_vecs [4];

  initial begin
    int cyc;
    int n;
    rst = 1'b1; run = 1'b0; code_w_en = 1'b0; code_addr_in = '0; code_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    alu_vecs[0] = '{3'd0, 8'h05, 8'h03, 8'h08, "add_5_3"};
    alu_vecs[1] = '{3'd0, 8'hFF, 8'h01, 8'h00, "add_wrap"};
    alu_vecs[2] = '{3'd1, 8'h05, 8'h03, 8'h02, "sub_5_3"};
    alu_vecs[3] = '{3'd1, 8'h03, 8'h05, 8'hFE, "sub_neg"};
    alu_vecs[4] = '{3'd2, 8'hF0, 8'h3C, 8'h30, "and"};
    alu_vecs[5] = '{3'd3, 8'hF0, 8'h0F, 8'hFF, "or"};
    alu_vecs[6] = '{3'd4, 8'hAA, 8'hFF, 8'h55, "xor"};
    alu_vecs[7] = '{3'd5, 8'h81, 8'h00, 8'h02, "shl"};
    alu_vecs[8] = '{3'd6, 8'h81, 8'h00, 8'h40, "shr"};
    alu_vecs[9] = '{3'd7, 8'h7E, 8'h11, 8'h7E, "mov"};

    br_vecs[0].prog = '{16'h4105, 16'h0809, 16'h6810, 16'hF800, 16'h7800};
    br_vecs[0].cycles = 11; br_vecs[0].name = "jz_z_set";
    br_vecs[1].prog = '{16'h4105, 16'h0009, 16'h6810, 16'hF800, 16'h7800};
    br_vecs[1].cycles = 11; br_vecs[1].name = "jz_z_clear";
    br_vecs[2].prog = '{16'h6010, 16'hF800, 16'h7800, 16'h7800, 16'h7800};
    br_vecs[2].cycles = 5;  br_vecs[2].name = "jmp";
    br_vecs[3].prog = '{16'h41FF, 16'h4201, 16'h000A, 16'h7010, 16'hF800};
    br_vecs[3].cycles = 14; br_vecs[3].name = "jc_c_set";
`ifdef DATAPATH_MC_BRANCH_EN
    br_vecs[0].exp_pc = 9'h011; br_vecs[1].exp_pc = 9'h004;
    br_vecs[2].exp_pc = 9'h011; br_vecs[3].exp_pc = 9'h011;
`else
    br_vecs[0].exp_pc = 9'h004; br_vecs[1].exp_pc = 9'h004;
    br_vecs[2].exp_pc = 9'h002; br_vecs[3].exp_pc = 9'h005;
`endif

    // ---------------- reset state ----------------
    do_reset();
    check("rst_pc", pc_out, 0);
    check("rst_debug", debug, 0);
    check("rst_halted", halted, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);

    // Fill the whole code store with NOP (opcode 01111)
    for (int a = 0; a < 512; a++) load_word(9'(a), 16'h7800);

    // ---------------- PC wrap through 0x1FF ----------------
    do_reset();
    run = 1'b1;
    n = 0;
    while (pc_out != 9'h1FF && n < 2000) begin tick(); n++; end
    check("wrap_reach_1ff", pc_out, 9'h1FF);
    n = 0;
    while (pc_out == 9'h1FF && n < 10) begin tick(); n++; end
    check("wrap_to_zero", pc_out, 0);
    run = 1'b0;
    repeat (6) tick();
    check("wrap_hold_pc", pc_out, 0);
    check("nop_no_write", debug, 0);

    // ---------------- ALU table ----------------
    for (int i = 0; i < 10; i++) begin
      do_reset();
      load_word(9'd0, {8'h41, alu_vecs[i].a});
      load_word(9'd1, {8'h42, alu_vecs[i].b});
      load_word(9'd2, {2'b00, alu_vecs[i].op, 3'b011, 2'b00, 3'b001, 3'b010});
      load_word(9'd3, 16'hF800);
      run_to_halt(cyc);
      check({alu_vecs[i].name, "_cycles"}, cyc, 11);
      check({alu_vecs[i].name, "_debug"}, debug, alu_vecs[i].exp_y);
      check({alu_vecs[i].name, "_pc"}, pc_out, 9'h004);
    end

    // ---------------- branch table ----------------
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int w = 0; w < 5; w++) load_word(9'(w), br_vecs[i].prog[w]);
      load_word(9'h010, 16'hF800);
      run_to_halt(cyc);
      check({br_vecs[i].name, "_cycles"}, cyc, br_vecs[i].cycles);
      check({br_vecs[i].name, "_pc"}, pc_out, br_vecs[i].exp_pc);
    end

    // ---------------- store / load handshake ----------------
    do_reset();
    load_word(9'd0, 16'h4405);   // LDI r4,5
    load_word(9'd1, 16'h5020);   // ST  mem[0x20] <- r4
    load_word(9'd2, 16'h4C20);   // LD  r4 <- mem[0x20]
    load_word(9'd3, 16'h5020);   // ST  mem[0x20] <- r4
    load_word(9'd4, 16'hF800);   // HALT
    run = 1'b1;
    mem_service("st_slow", 3, 1'b1, 10'h020, 8'h05, 8'h00, n);
    check("st_req_latency", n, 5);
    mem_service("ld_fast", 0, 1'b0, 10'h020, 8'h00, 8'hA5, n);
    check("ld_before_wb", debug, 8'h05);
    tick();
    check("ld_after_wb", debug, 8'hA5);
    mem_service("st_after_ld", 1, 1'b1, 10'h020, 8'hA5, 8'h00, n);
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    run = 1'b0;
    check("mem_halted", halted, 1);
    check("mem_pc", pc_out, 9'h005);

    // ---------------- run dropped mid-instruction ----------------
    do_reset();
    load_word(9'd0, 16'h4107);   // LDI r1,7
    load_word(9'd1, 16'h0209);   // ADD r2,r1,r1
    load_word(9'd2, 16'hF800);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check("hold_ldi_done", debug, 8'h07);
    repeat (8) tick();
    check("hold_pc", pc_out, 9'h001);
    check("hold_not_halted", halted, 0);
    check("hold_debug", debug, 8'h07);
    run_to_halt(cyc);
    check("resume_cycles", cyc, 5);
    check("resume_debug", debug, 8'h0E);
    check("resume_pc", pc_out, 9'h003);

    // ---------------- reset during MEM with ack pending ----------------
    do_reset();
    load_word(9'd0, 16'h4405);
    load_word(9'd1, 16'h5020);
    load_word(9'd2, 16'hF800);
    run = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin tick(); n++; end
    check("rstmem_req_seen", dmem_req, 1);
    tick();
    rst = 1'b1; run = 1'b0; dmem_ack = 1'b1;
    tick();
    check("rstmem_req_drop", dmem_req, 0);
    check("rstmem_pc", pc_out, 0);
    check("rstmem_debug", debug, 0);
    rst = 1'b0; dmem_ack = 1'b0;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    check("stray_ack_req", dmem_req, 0);
    check("stray_ack_pc", pc_out, 0);
    check("stray_ack_halted", halted, 0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised multicycle successor of the single-cycle 8-bit datapath. It has an internal fetch/decode/execute/memory state machine in place of the external microprogrammed control. It also adds configurable data and address widths, conditional branches, a HALT instruction, and a req/ack handshake to an external data memory. It sits at the top of the processor core. It instantiates the existing `register_bank`, `alu` and `memory_bank` (code store) blocks.

## Interface
- `DATA_W`, 8: datapath/register/ALU width; must be ≥ 8.
- `CODE_ADDR_W`, 9: code memory address width; must be ≤ 11.
- `DATA_ADDR_W`, 10: external data memory address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `run` in 1: permits instruction fetch.
- `code_w_en` in 1: code store write strobe; honoured only while `run`=0.
- `code_addr_in` in CODE_ADDR_W: code store write address.
- `code_in` in 16: code store write data.
- `dmem_req` out 1: data memory request; held high until acknowledged.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`.
- `dmem_addr` out DATA_ADDR_W: address, valid while `dmem_req`.
- `dmem_wdata` out DATA_W: store data, valid while `dmem_req`.
- `dmem_rdata` in DATA_W: load data, sampled in the cycle `dmem_ack`=1.
- `dmem_ack` in 1: one-cycle completion pulse.
- `halted` out 1: high after HALT executes, until `rst`.
- `pc_out` out CODE_ADDR_W: current PC.
- `debug` out DATA_W: last value written to the register file.

## Operation
- Instruction word: `ir[15:11]` opcode, `ir[10:8]` rd, `ir[5:3]` ra, `ir[2:0]` rb, `ir[7:0]` imm (zero-extended to DATA_W).
- Opcodes:
  - `00ooo`: ALU op `ooo`; rd ← ra op rb; flags updated.
  - `01000` LDI: rd ← imm.
  - `01001` LD: rd ← mem[imm].
  - `01010` ST: mem[imm] ← ra.
  - `01100` JMP: PC ← `ir[CODE_ADDR_W-1:0]`.
  - `01101` JZ and `01110` JC: jump if Z or C set.
  - `11111` HALT.
  - All other opcodes: NOP.
- Flags are 4 bits: Z bit0, C bit1, N bit2, V bit3. Only ALU ops write flags.
- Data address is imm zero-extended or truncated to DATA_ADDR_W.
- States:
  - FETCH: code address = PC. Advance to DECODE only if `run`=1; otherwise stay.
  - DECODE: latch IR from code store; PC ← PC+1 (wraps modulo 2^CODE_ADDR_W). Next state is MEM for LD/ST, HALT for HALT, else EXEC.
  - EXEC: perform the ALU/LDI write, flags write or branch PC load; → FETCH.
  - MEM: assert req. On `dmem_ack`: for LD → WB (data captured); for ST → FETCH.
  - WB: rd ← captured data; → FETCH.
  - HALT: terminal state; `halted`=1; ignores `run`.
- `run` is sampled only in FETCH. Deasserting it mid-instruction lets that instruction complete.
- `code_w_en` with `run`=1 is ignored. The code store address mux selects `code_addr_in` only when a write is accepted.
- A `dmem_ack` outside MEM is ignored.

## Timing
- Reset values:
  - State FETCH, PC 0, IR 0, flags 0, all registers 0.
  - `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0.
  - `halted` 0, `debug` 0, `pc_out` 0.
- Code store read is synchronous, one cycle.
- Instruction latency:
  - ALU, LDI, branch, NOP: 3 cycles.
  - ST: 3 + N cycles, where N = cycles from req to ack, N ≥ 0.
  - LD: 4 + N cycles.
  - HALT: 2 cycles to `halted`=1.
- `dmem_req` rises on entry to MEM. Address, data and we stay stable until the ack cycle. `dmem_req` is low the cycle after ack.
- Register write and the `debug` update are visible the cycle after EXEC/WB.
- A branch-taken PC load overrides the DECODE increment.
- `rst` during MEM drops `dmem_req` the next cycle; an ack arriving in the reset cycle is discarded.
- `rst` has priority over every other input.

## Configuration
- `DATAPATH_MC_BRANCH_EN`:
  - Defined: JMP, JZ and JC behave as above.
  - Undefined: opcodes `01100`–`01110` decode as NOP (3 cycles, PC sequential), and no branch mux is generated.

## Structure
- `datapath_pkg`:
  - opcode localparams
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - flag bit indices
  - instruction field slice positions
- Sub-module `dp_ctrl_fsm`: state register, next-state logic, and control strobes (reg write, flags write, PC load/inc, req). The `datapath_mc` top holds PC, IR, the mem capture register, and the bank/ALU/code-store instances.

## Test plan
- Load LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT, then raise `run` → r3=8, `debug`=8, `halted` after 11 cycles, PC=4.
- ST r1 → addr 0x20 with ack delayed 3 cycles → `dmem_req` high for 4 cycles, `dmem_addr`=0x020, `dmem_wdata`=5 stable, `dmem_we`=1.
- LD r4 from 0x20 with `dmem_rdata`=0xA5 and immediate ack → r4=0xA5 after 4 cycles.
- SUB r0,r1,r1 then JZ 0x10 → PC=0x10. With Z clear → PC sequential. With the macro undefined → always sequential.
- PC at 0x1FF executing a NOP → PC wraps to 0. `run`=0 during an ALU instruction → the instruction completes, then the FSM holds in FETCH.
- Assert `rst` during MEM with ack pending → `dmem_req`=0 the next cycle, PC=0; a later stray ack has no effect.
